// File: rtl/frame_test_pkg.sv
// Shared types, ROM contents and LFSR tap selection for the frame test generator.
package frame_test_pkg;

    typedef enum logic [1:0] {
        MODE_ROM  = 2'd0,
        MODE_CNT  = 2'd1,
        MODE_PRBS = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitRdy,
        StEndWait,
        StDelay,
        StHold
    } state_t;

    // ROM table as 32-bit words; callers truncate to their data width.
    function automatic logic [31:0] rom_init(input int unsigned idx);
        case (idx)
            0:       return 32'h0000_00AA;
            1:       return 32'h0000_0000;
            2:       return 32'h0000_00AA;
            3:       return 32'h0000_00FF;
            4:       return 32'h0000_0055;
            default: return idx + 32'd1;
        endcase
    endfunction

    // Tap mask (bit n-1 for term x^n) for a Fibonacci LFSR that shifts towards the MSB.
    function automatic logic [31:0] prbs_taps(input int unsigned width);
        case (width)
            16:      return 32'h0000_D008;
            32:      return 32'h8020_0003;
            default: return 32'h0000_00B8;
        endcase
    endfunction

endpackage

// File: rtl/frame_test_gen_prbs.sv
// Fibonacci LFSR word source; reloads to all-ones and steps once per accepted word.
module prbs_gen
    import frame_test_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic             advance,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(prbs_taps(WIDTH));

    logic [WIDTH-1:0] lfsr_q;
    logic             feedback;

    assign feedback = ^(lfsr_q & TAPS);

    always_ff @(posedge clk) begin
        if (reset || seed_load) begin
            lfsr_q <= '1;
        end else if (advance) begin
            lfsr_q <= {lfsr_q[WIDTH-2:0], feedback};
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/frame_test_gen.sv
// Frame generator driving a byte-serial transmitter's send/ready handshake with ROM,
// counting or PRBS words, separated by a programmable inter-frame delay.
module frame_test_gen
    import frame_test_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MEM_SIZE     = 32,
    parameter int unsigned WAIT_TIME_US = 10000,
    parameter int unsigned CLK_PD_NS    = 10,
    parameter int unsigned WAIT_TIME    = (WAIT_TIME_US * 1000) / CLK_PD_NS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic                      single,
    input  logic [1:0]                mode,
    input  logic [$clog2(MEM_SIZE):0] length,
    input  logic                      ready,
    output logic                      send,
    output logic [DATA_W-1:0]         data,
    output logic                      frame_done,
    output logic [15:0]               frame_count
);

    localparam int unsigned      LEN_W    = $clog2(MEM_SIZE) + 1;
    localparam int unsigned      CNT_W    = (WAIT_TIME > 1) ? $clog2(WAIT_TIME) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MEM_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIME - 1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   index_q, index_d;
    logic [LEN_W-1:0]   len_q, len_d;
    mode_t              mode_q, mode_d;
    logic               single_q, single_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               done_q, done_d;
    logic [15:0]        count_q, count_d;
    logic               seed_load;
    logic               advance;
    logic [DATA_W-1:0]  prbs_word;

    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_CNT;
            2'd2:    return MODE_PRBS;
            default: return MODE_ROM;
        endcase
    endfunction

    prbs_gen #(
        .WIDTH (DATA_W)
    ) u_prbs (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .advance   (advance),
        .q         (prbs_word)
    );

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        len_d     = len_q;
        mode_d    = mode_q;
        single_d  = single_q;
        wait_d    = wait_q;
        done_d    = 1'b0;
        count_d   = count_q;
        seed_load = 1'b0;
        advance   = 1'b0;
        send      = 1'b0;
        case (state_q)
            StIdle: begin
                index_d   = '0;
                seed_load = 1'b1;
                if (run && ready && (length != '0)) begin
                    mode_d   = decode_mode(mode);
                    len_d    = (length > MAX_LEN) ? MAX_LEN : length;
                    single_d = single;
                    state_d  = StSend;
                end
            end
            StSend: begin
                send = 1'b1;
                // ready falling while send is high means the word was taken.
                if (!ready) begin
                    index_d = index_q + 1'b1;
                    advance = 1'b1;
                    if (index_q == len_q - 1'b1) begin
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                        state_d = StEndWait;
                    end else begin
                        state_d = StWaitRdy;
                    end
                end
            end
            StWaitRdy: begin
                if (ready) state_d = StSend;
            end
            StEndWait: begin
                wait_d = '0;
                if (ready) state_d = StDelay;
            end
            StDelay: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == CNT_LAST) state_d = single_q ? StHold : StIdle;
            end
            StHold: begin
                if (!run) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case (mode_q)
            MODE_CNT:  data = DATA_W'(index_q);
            MODE_PRBS: data = prbs_word;
            default:   data = DATA_W'(rom_init(32'(index_q)));
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            index_q  <= '0;
            len_q    <= '0;
            mode_q   <= MODE_ROM;
            single_q <= 1'b0;
            wait_q   <= '0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            single_q <= single_d;
            wait_q   <= wait_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign frame_done  = done_q;
    assign frame_count = count_q;

endmodule
